sha_msg_schedule: RTL and testbench

Sequential, parametrised SHA-2 message-schedule generator.
- Accepts one 16-word message block serially over a valid/ready input.
- Streams W[0..ROUNDS-1] one word per cycle over a valid/ready output to the compression round engine.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds) by parameter.
- Replaces the flat all-words-at-once combinational expansion with a 16-entry rolling window.

---
 rtl/sha_pkg.sv | 34 +++
 rtl/sha_sigma.sv | 33 +++
 rtl/sha_msg_schedule.sv | 130 +++++++++++++
 tb/tb_sha_msg_schedule.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-2 message-schedule block: FSM state encoding,
// the rotate/shift amounts of the small sigma functions for both word widths,
// and the legal-parameter check used at elaboration.
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // SHA-256 (32-bit words)
  localparam int SHA256_S0_R1 = 7;
  localparam int SHA256_S0_R2 = 18;
  localparam int SHA256_S0_SH = 3;
  localparam int SHA256_S1_R1 = 17;
  localparam int SHA256_S1_R2 = 19;
  localparam int SHA256_S1_SH = 10;

  // SHA-512 (64-bit words)
  localparam int SHA512_S0_R1 = 1;
  localparam int SHA512_S0_R2 = 8;
  localparam int SHA512_S0_SH = 7;
  localparam int SHA512_S1_R1 = 19;
  localparam int SHA512_S1_R2 = 61;
  localparam int SHA512_S1_SH = 6;

  // 32-bit words allow 16..128 rounds; 64-bit words need exactly 80.
  function automatic bit params_legal(input int word_w, input int rounds);
    return ((word_w == 32) && (rounds >= 16) && (rounds <= 128)) ||
           ((word_w == 64) && (rounds == 80));
  endfunction

endpackage

// File: rtl/sha_sigma.sv
// Small sigma function of SHA-2 (sigma0 or sigma1, chosen by i_sel) for a
// 32-bit or 64-bit word. Purely combinational.
module sha_sigma #(
  parameter int WORD_W = 32
) (
  input  logic              i_sel,  // 0: sigma0, 1: sigma1
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_y
);
  import sha_pkg::*;

  localparam int S0_R1 = (WORD_W == 64) ? SHA512_S0_R1 : SHA256_S0_R1;
  localparam int S0_R2 = (WORD_W == 64) ? SHA512_S0_R2 : SHA256_S0_R2;
  localparam int S0_SH = (WORD_W == 64) ? SHA512_S0_SH : SHA256_S0_SH;
  localparam int S1_R1 = (WORD_W == 64) ? SHA512_S1_R1 : SHA256_S1_R1;
  localparam int S1_R2 = (WORD_W == 64) ? SHA512_S1_R2 : SHA256_S1_R2;
  localparam int S1_SH = (WORD_W == 64) ? SHA512_S1_SH : SHA256_S1_SH;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;

  // Both variants are formed; the select is tied off per instance.
  always_comb begin
    s0  = rotr(i_x, S0_R1) ^ rotr(i_x, S0_R2) ^ (i_x >> S0_SH);
    s1  = rotr(i_x, S1_R1) ^ rotr(i_x, S1_R2) ^ (i_x >> S1_SH);
    o_y = i_sel ? s1 : s0;
  end

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message-schedule generator. Loads a 16-word block serially, then
// streams W[0..ROUNDS-1] from a 16-entry rolling window r[0..15] that always
// holds W[t..t+15]; each accepted word shifts the window and appends W[t+16].
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and o_w/o_t/o_last hold steady
// while o_w_valid=1 and i_w_ready=0.
module sha_msg_schedule #(
  parameter  int WORD_W = 32,
  parameter  int ROUNDS = 64,
  localparam int T_W    = $clog2(ROUNDS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [WORD_W-1:0] i_m,
  input  logic              i_m_valid,
  output logic              o_m_ready,
  output logic [WORD_W-1:0] o_w,
  output logic              o_w_valid,
  input  logic              i_w_ready,
  output logic [T_W-1:0]    o_t,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done
);
  import sha_pkg::*;

  if (!params_legal(WORD_W, ROUNDS)) begin : g_bad_params
    $error("sha_msg_schedule: illegal WORD_W/ROUNDS combination");
  end

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [T_W-1:0]    t_q, t_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] r_q [16];
  logic [WORD_W-1:0] r_d [16];
  logic [WORD_W-1:0] sig0, sig1, w_next;

  sha_sigma #(.WORD_W(WORD_W)) u_sigma0 (.i_sel(1'b0), .i_x(r_q[1]),  .o_y(sig0));
  sha_sigma #(.WORD_W(WORD_W)) u_sigma1 (.i_sel(1'b1), .i_x(r_q[14]), .o_y(sig1));

  // W[t+16] from the current window; additions wrap at WORD_W bits.
  always_comb begin
    w_next = sig1 + r_q[9] + sig0 + r_q[0];
  end

  // Next-state, window shift and round-index logic; abort overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    done_d  = 1'b0;
    r_d     = r_q;
    if (i_abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      t_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
          end
        end
        ST_LOAD: begin
          if (i_m_valid) begin
            for (int k = 0; k < 15; k++) r_d[k] = r_q[k+1];
            r_d[15] = i_m;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = ST_EMIT;
              t_d     = '0;
            end
          end
        end
        ST_EMIT: begin
          if (i_w_ready) begin
            for (int k = 0; k < 15; k++) r_d[k] = r_q[k+1];
            r_d[15] = w_next;
            if (t_q == T_W'(ROUNDS - 1)) begin
              state_d = ST_IDLE;
              t_d     = '0;
              done_d  = 1'b1;
            end else begin
              t_d = t_q + T_W'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and window registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < 16; k++) r_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      for (int k = 0; k < 16; k++) r_q[k] <= r_d[k];
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    o_m_ready = (state_q == ST_LOAD);
    o_w_valid = (state_q == ST_EMIT);
    o_w       = r_q[0];
    o_t       = t_q;
    o_last    = (state_q == ST_EMIT) && (t_q == T_W'(ROUNDS - 1));
    o_busy    = busy_q;
    o_done    = done_q;
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Bench for sha_msg_schedule: one SHA-256 instance and one SHA-512 instance
// share the stimulus bus; sel64 picks which one a test drives and observes.
module tb_sha_msg_schedule;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic [63:0] m;
  logic        m_valid, w_ready, abort, start, sel64;

  logic        m_ready32, w_valid32, last32, busy32, done32;
  logic [31:0] w32;
  logic [5:0]  t32;
  logic        m_ready64, w_valid64, last64, busy64, done64;
  logic [63:0] w64;
  logic [6:0]  t64;

  sha_msg_schedule #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & ~sel64), .i_abort(abort),
    .i_m(m[31:0]), .i_m_valid(m_valid), .o_m_ready(m_ready32),
    .o_w(w32), .o_w_valid(w_valid32), .i_w_ready(w_ready), .o_t(t32),
    .o_last(last32), .o_busy(busy32), .o_done(done32));

  sha_msg_schedule #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start & sel64), .i_abort(abort),
    .i_m(m), .i_m_valid(m_valid), .o_m_ready(m_ready64),
    .o_w(w64), .o_w_valid(w_valid64), .i_w_ready(w_ready), .o_t(t64),
    .o_last(last64), .o_busy(busy64), .o_done(done64));

  logic        ob_m_ready, ob_w_valid, ob_last, ob_busy, ob_done;
  logic [63:0] ob_w;
  logic [6:0]  ob_t;
  always_comb begin
    ob_m_ready = sel64 ? m_ready64 : m_ready32;
    ob_w_valid = sel64 ? w_valid64 : w_valid32;
    ob_last    = sel64 ? last64    : last32;
    ob_busy    = sel64 ? busy64    : busy32;
    ob_done    = sel64 ? done64    : done32;
    ob_w       = sel64 ? w64       : {32'h0, w32};
    ob_t       = sel64 ? t64       : {1'b0, t32};
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] w_model[80];
  logic [63:0] got[80];
  logic [63:0] msg[16];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference schedule, textbook form W[t] = s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16].
  function automatic logic [31:0] rr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic build_model(input bit is64);
    logic [31:0] a, b;
    logic [63:0] c, d;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        w_model[t] = is64 ? msg[t] : {32'h0, msg[t][31:0]};
      end else if (is64) begin
        c = w_model[t-2];
        d = w_model[t-15];
        w_model[t] = (rr64(c, 19) ^ rr64(c, 61) ^ (c >> 6)) + w_model[t-7] +
                     (rr64(d, 1) ^ rr64(d, 8) ^ (d >> 7)) + w_model[t-16];
      end else begin
        a = w_model[t-2][31:0];
        b = w_model[t-15][31:0];
        w_model[t] = {32'h0, (rr32(a, 17) ^ rr32(a, 19) ^ (a >> 10)) + w_model[t-7][31:0] +
                             (rr32(b, 7) ^ rr32(b, 18) ^ (b >> 3)) + w_model[t-16][31:0]};
      end
    end
  endtask

  task automatic set_msg(input int sel);
    for (int i = 0; i < 16; i++) begin
      case (sel)
        0:       msg[i] = (i == 0) ? 64'h61626380 : (i == 15) ? 64'h18 : 64'h0;
        1:       msg[i] = (i == 1) ? 64'h1 : 64'h0;
        default: msg[i] = {$urandom(), $urandom()};
      endcase
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is64;
    int          msg_sel;   // 0 "abc", 1 M1=1, 2 random
    int          rdy_pct;
    int          val_pct;
    int          abort_at;  // -1: no abort
    bit          poke;      // pulse i_start while busy
    bit          chk16;
    logic [63:0] exp16;
    bit          chk17;
    logic [63:0] exp17;
  } vec_t;

  vec_t vecs[9];

  // Drive one block from start to done (or abort), scoring every word.
  task automatic run_vec(input vec_t v);
    int rounds, beats, idx, beat16_cyc, first_cyc;
    bit done_pend, finished, aborted, stall_prev;
    logic [63:0] hold_w;
    logic [6:0]  hold_t;
    logic [63:0] e;
    sel64  = v.is64;
    rounds = v.is64 ? 80 : 64;
    set_msg(v.msg_sel);
    build_model(v.is64);
    exp_q.delete();
    for (int t = 0; t < rounds; t++) exp_q.push_back(w_model[t]);
    @(negedge clk);
    start = 1'b1; m_valid = 1'b0; w_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    beats = 0; idx = 0; done_pend = 0; finished = 0; aborted = 0; stall_prev = 0;
    beat16_cyc = -1; first_cyc = -1; hold_w = '0; hold_t = '0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (aborted) begin
        abort = 1'b0;
        chk("abort_w_valid", {63'h0, ob_w_valid}, 64'h0);
        chk("abort_m_ready", {63'h0, ob_m_ready}, 64'h0);
        chk("abort_busy", {63'h0, ob_busy}, 64'h0);
        for (int k = 0; k < 3; k++) begin
          chk("abort_no_done", {63'h0, ob_done}, 64'h0);
          @(negedge clk);
        end
        finished = 1;
      end else if (done_pend) begin
        chk("done_pulse", {63'h0, ob_done}, 64'h1);
        chk("done_w_valid", {63'h0, ob_w_valid}, 64'h0);
        chk("done_busy", {63'h0, ob_busy}, 64'h0);
        @(negedge clk);
        chk("done_one_cycle", {63'h0, ob_done}, 64'h0);
        finished = 1;
      end else begin
        chk("done_low", {63'h0, ob_done}, 64'h0);
        if (stall_prev) begin
          chk("stall_w", ob_w, hold_w);
          chk("stall_t", {57'h0, ob_t}, {57'h0, hold_t});
        end
        if (ob_w_valid && first_cyc < 0) begin
          first_cyc = cyc;
          chk("first_latency", 64'(first_cyc), 64'(beat16_cyc + 1));
        end
        // input side
        if (beats < 16 && $urandom_range(99) < v.val_pct) begin
          m = msg[beats];
          m_valid = 1'b1;
          if (ob_m_ready) begin
            beats++;
            if (beats == 16) beat16_cyc = cyc;
          end
        end else begin
          m = {$urandom(), $urandom()};
          m_valid = 1'b0;
        end
        // output side
        w_ready = ($urandom_range(99) < v.rdy_pct);
        if (v.abort_at >= 0 && ob_w_valid && int'(ob_t) == v.abort_at) begin
          abort = 1'b1;
          w_ready = 1'b0;
          aborted = 1;
        end
        stall_prev = 0;
        if (ob_w_valid && !aborted) begin
          if (w_ready) begin
            if (exp_q.size() == 0) begin
              chk("extra_word", 64'h1, 64'h0);
            end else begin
              e = exp_q.pop_front();
              chk("w", ob_w, e);
              chk("t", {57'h0, ob_t}, 64'(idx));
              chk("last", {63'h0, ob_last}, {63'h0, (idx == rounds - 1)});
              got[idx] = ob_w;
              if (idx == rounds - 1) done_pend = 1;
              idx++;
            end
          end else begin
            stall_prev = 1;
            hold_w = ob_w;
            hold_t = ob_t;
          end
        end
        start = v.poke && !done_pend && !aborted && ($urandom_range(3) == 0);
        @(negedge clk);
      end
    end
    if (!finished) chk("timeout", 64'h1, 64'h0);
    if (!aborted) chk("all_words_seen", 64'(exp_q.size()), 64'h0);
    m_valid = 1'b0; w_ready = 1'b0; start = 1'b0; abort = 1'b0;
    if (v.chk16) chk("w16", got[16], v.exp16);
    if (v.chk17) chk("w17", got[17], v.exp17);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m = '0; m_valid = 1'b0; w_ready = 1'b0; abort = 1'b0; start = 1'b0; sel64 = 1'b0;

    vecs[0] = '{0, 0, 100, 100, -1, 0, 1, 64'h61626380, 1, 64'h000F0000};
    vecs[1] = '{1, 1, 100, 100, -1, 0, 1, 64'h8100000000000000, 0, 64'h0};
    vecs[2] = '{0, 0, 60, 70, -1, 0, 1, 64'h61626380, 1, 64'h000F0000};
    vecs[3] = '{0, 2, 50, 50, -1, 0, 0, 64'h0, 0, 64'h0};
    vecs[4] = '{1, 2, 70, 60, -1, 0, 0, 64'h0, 0, 64'h0};
    vecs[5] = '{0, 0, 100, 100, 30, 0, 0, 64'h0, 0, 64'h0};
    vecs[6] = '{0, 0, 100, 100, -1, 0, 1, 64'h61626380, 1, 64'h000F0000};
    vecs[7] = '{0, 0, 100, 100, -1, 1, 1, 64'h61626380, 1, 64'h000F0000};
    vecs[8] = '{1, 1, 40, 80, -1, 1, 1, 64'h8100000000000000, 0, 64'h0};

    // reset state of both instances
    #12;
    chk("rst32_outs", {w32, 6'h0, t32, w_valid32, m_ready32, last32, busy32, done32, 15'h0}, 64'h0);
    chk("rst64_w", w64, 64'h0);
    chk("rst64_ctl", {52'h0, t64, w_valid64, m_ready64, last64, busy64, done64}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // abort together with start while idle: stays idle
    sel64 = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {63'h0, ob_busy}, 64'h0);
    chk("abort_start_m_ready", {63'h0, ob_m_ready}, 64'h0);
    @(negedge clk);
    chk("abort_start_busy2", {63'h0, ob_busy}, 64'h0);

    // asynchronous reset after 7 load beats
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_msg(0);
    for (int i = 0; i < 7; i++) begin
      m = msg[i]; m_valid = 1'b1;
      @(negedge clk);
    end
    m_valid = 1'b0;
    chk("pre_rst_busy", {63'h0, ob_busy}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {ob_w[31:0], 18'h0, ob_t, ob_w_valid, ob_m_ready, ob_last, ob_busy, ob_done},
        64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {63'h0, ob_busy}, 64'h0);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
